// File: rtl/adc_tape_slicer.sv
// adc_tape_slicer: slices the ADC audio stream into the cassette bit,
// using a running-average DC tracker, hysteresis, and edge-period timing.
module adc_tape_slicer #(
  parameter int AVG_LOG2 = 9,
  parameter int HYST     = 100,
  parameter int INVERT   = 1,
  parameter int TIMEOUT  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] din,
  input  logic        din_sync,
  output logic        bit_out,
  output logic        bit_edge,
  output logic [11:0] level_avg,
  output logic [15:0] period,
  output logic        active
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TW    = 12 + AVG_LOG2;

  localparam logic signed [13:0] HYST14  = 14'(HYST);
  localparam logic               INV_BIT = 1'(INVERT);
  localparam logic [15:0]        TO16    = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    ACC,
    CMP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                sync_d;
  logic [11:0]         smp;
  logic [11:0]         rd_data;
  logic [11:0]         mem [DEPTH];
  logic [AVG_LOG2-1:0] ptr;
  logic [AVG_LOG2:0]   fill;
  logic [TW-1:0]       total;
  logic [15:0]         cnt;

  logic                start;
  logic                full;
  logic [11:0]         old;
  logic signed [13:0]  s14;
  logic signed [13:0]  lo;
  logic signed [13:0]  hi;
  logic                new_bit;
  logic                edge_now;
  logic [15:0]         cnt_inc;

  assign start = (din_sync != sync_d);
  assign full  = fill[AVG_LOG2];
  // Unwritten RAM words are never trusted: until the window is full
  // nothing is subtracted, so stale contents cannot leak in.
  assign old   = full ? rd_data : 12'd0;

  assign s14 = $signed({2'b00, smp});
  assign lo  = $signed({2'b00, level_avg}) - HYST14;
  assign hi  = $signed({2'b00, level_avg}) + HYST14;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    new_bit   = bit_out;
    edge_now  = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RD;
      RD:   state_nxt = ACC;
      ACC:  state_nxt = CMP;
      CMP: begin
        state_nxt = IDLE;
        if (s14 < lo) begin
          new_bit = INV_BIT;
        end else if (s14 > hi) begin
          new_bit = ~INV_BIT;
        end
        edge_now = (new_bit != bit_out);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window RAM: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      rd_data <= mem[ptr];
    end
    if (state == RD) begin
      mem[ptr] <= smp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d    <= 1'b0;
      smp       <= 12'd0;
      ptr       <= '0;
      fill      <= '0;
      total     <= '0;
      level_avg <= 12'd0;
      bit_out   <= 1'b0;
      bit_edge  <= 1'b0;
    end else begin
      sync_d   <= din_sync;
      bit_edge <= edge_now;
      if (state == IDLE && start) begin
        smp <= din;
      end
      if (state == RD) begin
        total <= total - TW'(old) + TW'(smp);
        ptr   <= ptr + 1'b1;
        if (!full) begin
          fill <= fill + 1'b1;
        end
      end
      if (state == ACC) begin
        level_avg <= total[TW-1:AVG_LOG2];
      end
      if (state == CMP) begin
        bit_out <= new_bit;
      end
    end
  end

  // cnt_inc is the cycle distance from the previous edge's cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 16'd0;
      period <= 16'd0;
      active <= 1'b0;
    end else if (edge_now) begin
      period <= cnt_inc;
      cnt    <= 16'd0;
      active <= 1'b1;
    end else begin
      cnt <= cnt_inc;
      if (cnt_inc == TO16) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_tape_slicer.sv
// tb_adc_tape_slicer: directed stimulus with a scoreboard of expected
// average / bit / edge values produced by a behavioural window model.
module tb_adc_tape_slicer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din;
  logic        din_sync;
  logic        bit_out;
  logic        bit_edge;
  logic [11:0] level_avg;
  logic [15:0] period;
  logic        active;

  always #5 clk = ~clk;

  adc_tape_slicer dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_sync  (din_sync),
    .bit_out   (bit_out),
    .bit_edge  (bit_edge),
    .level_avg (level_avg),
    .period    (period),
    .active    (active)
  );

  typedef struct {
    int   avg;
    logic b;
    logic e;
  } exp_t;

  exp_t sb[$];

  int   vectors = 0;
  int   errors  = 0;
  int   win[512];
  int   widx;
  int   wcnt;
  int   msum;
  logic mbit;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) win[i] = 0;
    widx = 0;
    wcnt = 0;
    msum = 0;
    mbit = 1'b0;
  endtask

  task automatic model_push(input int s);
    exp_t x;
    int   avg;
    logic nb;
    if (wcnt == 512) msum -= win[widx];
    else wcnt++;
    win[widx] = s;
    msum += s;
    widx = (widx + 1) % 512;
    avg = msum / 512;
    nb = mbit;
    if (s < avg - 100) nb = 1'b1;
    else if (s > avg + 100) nb = 1'b0;
    x.avg = avg;
    x.b   = nb;
    x.e   = (nb != mbit);
    mbit  = nb;
    sb.push_back(x);
  endtask

  task automatic send(input int s);
    exp_t x;
    @(negedge clk);
    din = 12'(s);
    din_sync = ~din_sync;
    model_push(s);
    repeat (4) @(posedge clk);
    #1;
    x = sb.pop_front();
    check("level_avg", {20'd0, level_avg}, x.avg);
    check("bit_out", {31'd0, bit_out}, {31'd0, x.b});
    check("bit_edge", {31'd0, bit_edge}, {31'd0, x.e});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit"}, {31'd0, bit_out}, 0);
    check({tag, "_edge"}, {31'd0, bit_edge}, 0);
    check({tag, "_avg"}, {20'd0, level_avg}, 0);
    check({tag, "_period"}, {16'd0, period}, 0);
    check({tag, "_active"}, {31'd0, active}, 0);
  endtask

  initial begin
    reset    = 1'b1;
    din      = 12'd0;
    din_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Build up a non-zero state, then reset in the middle of a sample.
    repeat (13) send(4095);
    send(0);
    check("pre_active", {31'd0, active}, 1);
    @(negedge clk);
    din = 12'd4095;
    din_sync = ~din_sync;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    din_sync = 1'b0;
    #1;
    check_reset_outputs("midacc");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Refill and basic slicing around a 2048 mid-level.
    repeat (512) send(2048);
    check("fill_avg", {20'd0, level_avg}, 2048);
    send(1900);
    send(2100);
    send(2200);

    // Rails: the band must not wrap near 0 or 4095.
    repeat (512) send(50);
    send(200);
    send(0);
    repeat (512) send(4050);
    send(3900);
    send(4095);

    // Full window replacement through the pointer wrap.
    repeat (512) send(3000);
    repeat (512) send(1000);
    check("wrap_avg", {20'd0, level_avg}, 1000);
    check("wrap_total", 32'(dut.total), 512000);

    // Edges exactly 1000 clk apart.
    send(3000);
    repeat (996) @(posedge clk);
    send(100);
    check("period_1000a", {16'd0, period}, 1000);
    check("active_on", {31'd0, active}, 1);
    repeat (996) @(posedge clk);
    send(3000);
    check("period_1000b", {16'd0, period}, 1000);

    // Activity timeout and period saturation.
    repeat (49999) @(posedge clk);
    #1;
    check("active_before_to", {31'd0, active}, 1);
    @(posedge clk);
    #1;
    check("active_at_to", {31'd0, active}, 0);
    repeat (16000) @(posedge clk);
    send(100);
    check("period_sat", {16'd0, period}, 32'hFFFF);
    check("active_again", {31'd0, active}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adc_tape_slicer.md
# adc_tape_slicer

Converts the mono 12-bit audio stream from the ADC front end (`ltc2308`, one sample per `dout_sync` toggle) into the 1-bit cassette level that feeds `mc10.cin` and the tape overlay. A 2^AVG_LOG2-sample running average tracks the DC level, and a hysteresis comparator against that average produces the bit. The block also measures the cycle count between bit transitions and raises an activity flag while edges keep arriving. It sits between `ltc2308` and the tape-input mux in `emu`, and replaces the inline shift-register averager there.

## Interface
- AVG_LOG2, 9: log2 of the averaging window (512 samples).
- HYST, 100: hysteresis half-width in ADC LSBs.
- INVERT, 1: 1 = sample below the band gives bit 1 (CoCo/MC-10 polarity).
- TIMEOUT, 50000: clk cycles without an edge before `active` drops; ≤ 65535.

Ports:
- clk  in  1: system clock (CLK_50M domain, same as `ltc2308`).
- reset  in  1: asynchronous, active-high.
- din  in  12: ADC sample, unsigned.
- din_sync  in  1: toggles once per new sample; same clock domain.
- bit_out  out  1: sliced cassette bit.
- bit_edge  out  1: one-cycle pulse on every `bit_out` change.
- level_avg  out  12: current running average.
- period  out  16: clk cycles between the last two edges, saturating.
- active  out  1: an edge occurred within the last TIMEOUT cycles.

## Operation
- Reset values: bit_out=0, bit_edge=0, level_avg=0, period=0, active=0. Internal state also resets: total=0, ptr=0, fill=0, cnt=0, sync_d=0.
- The window is a circular buffer of 2^AVG_LOG2 x 12 bits (block RAM), with a write/read pointer `ptr` that wraps modulo 2^AVG_LOG2.
- The RAM is not cleared. A fill counter saturates at 2^AVG_LOG2. While `fill` is not full, the outgoing value is forced to 0.
- `total` is 12+AVG_LOG2 bits wide (21 at default) and never overflows.
- Update: total <= total − old + smp. Then level_avg <= total[11+AVG_LOG2:AVG_LOG2].
- During fill, the average under-reads by design. No special-casing is applied.
- Comparator uses 14-bit signed arithmetic, so the band never wraps at the rails:
  - lo = avg − HYST, hi = avg + HYST.
  - smp < lo → bit_out = INVERT.
  - smp > hi → bit_out = ~INVERT.
  - otherwise bit_out holds.
- State machine: IDLE → RD → ACC → CMP → IDLE.
  - IDLE: when din_sync ≠ sync_d, capture smp<=din and present RAM read address ptr.
  - RD: old data is valid. Compute total, write smp at ptr, ptr++, fill++ (saturating).
  - ACC: update level_avg.
  - CMP: compare, update bit_out, pulse bit_edge on change.
- sync_d <= din_sync every cycle. A toggle arriving while the FSM is not in IDLE is dropped; the ADC rate makes this unreachable in the system.
- Period counter:
  - `cnt` increments every cycle and saturates at 0xFFFF.
  - On bit_edge: period <= cnt, cnt <= 0, active <= 1.
  - When cnt reaches TIMEOUT: active <= 0.
  - If an edge and the timeout coincide, the edge wins.

## Timing
- Toggle detected at edge T (din_sync ≠ sync_d) → RAM read issued at T. Timeline: total at T+1, level_avg at T+2, bit_out/bit_edge at T+3.
- bit_edge is high exactly one cycle, coincident with the new bit_out value.
- period is updated in the same cycle as bit_edge and counts cycles from the previous edge's cycle.
- Asserting reset mid-pipeline aborts the sample: the FSM returns to IDLE and all outputs return to reset values immediately (asynchronous).
- The first toggle after reset release is processed normally if sync_d differs.
- Wrap: after sample 2^AVG_LOG2, ptr=0 and the oldest sample is subtracted from then on.

## Test plan
- Reset, feed 512 samples of 2048 at one toggle per 1042 clk → after the 512th, level_avg=2048 at T+2; bit_out stays 0 throughout; no bit_edge.
- Continuing from the above, one sample of 1900 (< 1948) → bit_out=1 and bit_edge pulse at T+3. Next 2100 (in band) → bit_out holds 1. Next 2200 (> 2148) → bit_out=0 with pulse.
- Rail safety: fill with 50, then sample 0 → no change (lo = −50). Fill with 4050, then 4095 → no change (hi = 4150).
- Wrap: 512×3000 then 512×1000 → level_avg=1000 exactly after the 1024th sample, total = 512000.
- Edges forced 1000 clk apart → period=1000 and active=1. Stop edges → active=0 exactly TIMEOUT cycles after the last edge. A 70000-cycle gap → period=0xFFFF.
- Assert reset during the ACC cycle → all outputs 0 immediately. Refill with 2048 → level_avg=2048 after 512 samples; no stale RAM contribution.
